// File: rtl/spi_flash_pkg.sv
// Shared constants for the W25Q32-subset SPI flash emulator: opcodes,
// status bit masks, JEDEC ID bytes and the transaction FSM states.
package spi_flash_pkg;

    localparam logic [7:0] CMD_WR_EN        = 8'h06;
    localparam logic [7:0] CMD_STATUS       = 8'h05;
    localparam logic [7:0] CMD_READ         = 8'h03;
    localparam logic [7:0] CMD_WRITE        = 8'h02;
    localparam logic [7:0] CMD_ERASE_SECTOR = 8'h20;
    localparam logic [7:0] CMD_JEDEC_ID     = 8'h9F;

    localparam logic [7:0] STATUS_WEL  = 8'h02;
    localparam logic [7:0] STATUS_BUSY = 8'h01;

    localparam int SECTOR_BYTES = 4096;

    localparam logic [7:0] JEDEC_MFR  = 8'hEF;
    localparam logic [7:0] JEDEC_TYPE = 8'h40;
    localparam logic [7:0] JEDEC_CAP  = 8'h16;

    typedef enum logic [2:0] {
        IDLE, OPCODE, ADDR, DATA_OUT, DATA_IN, IGNORE
    } fsm_state_t;

    // ID byte for a given count of completed bytes; the capacity byte repeats.
    function automatic logic [7:0] jedec_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return JEDEC_MFR;
            3'd1:    return JEDEC_TYPE;
            default: return JEDEC_CAP;
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings ss/sclk/mosi into the clk domain through SYNC_STAGES flops (>= 2)
// and produces single-cycle edge pulses for sclk and ss. All chains reset
// low, so an ss fall can only be reported after ss has been seen high.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    input  logic sclk,
    input  logic mosi,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_rise,
    output logic ss_fall
);
    logic [SYNC_STAGES-1:0] ss_q, sclk_q, mosi_q;
    logic                   ss_d, sclk_d;

    // Synchronizer chains plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
            ss_d   <= 1'b0;
            sclk_d <= 1'b0;
        end else begin
            ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            ss_d   <= ss_q[SYNC_STAGES-1];
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_d;
    assign ss_rise   =  ss_q[SYNC_STAGES-1]   & ~ss_d;
    assign ss_fall   = ~ss_q[SYNC_STAGES-1]   &  ss_d;
endmodule

// File: rtl/spi_flash_slave.sv
// SPI flash emulator (SPI modes 0/3) with byte-wide internal memory.
// Optional: define SPI_FLASH_JEDEC_ID_EN to answer opcode 9F with EF 40 16.
// Memory holds complemented bytes so a zero-initialised RAM reads as erased
// (all FF) and survives rst; ADDR_W must be in 9..24.
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int PROG_CYCLES  = 5000,
    parameter int ERASE_CYCLES = 300000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic wel,
    output logic cmd_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SECT  = (DEPTH < SECTOR_BYTES) ? DEPTH : SECTOR_BYTES;
    localparam int MAXC  = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
`ifdef SPI_FLASH_JEDEC_ID_EN
    localparam bit JEDEC_EN = 1'b1;
`else
    localparam bit JEDEC_EN = 1'b0;
`endif

    logic mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;
    fsm_state_t state, state_nxt;
    logic [2:0] bit_cnt, byte_cnt;
    logic [6:0] sr;
    logic [7:0] tx, cmd, rx_byte, cur_op, tx_nxt, status_byte;
    logic [ADDR_W-1:0] addr_sr, ptr, a_new, rd_idx, eptr;
    logic [ADDR_W:0] sweep_left;
    logic [CNT_W-1:0] busy_cnt;
    logic rx_done, op_err, prog_wrote, prog_we, commit, erase_ok, erase_bad;
    logic [7:0] mem_n [DEPTH];

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi),
        .mosi_s(mosi_s), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
        .ss_rise(ss_rise), .ss_fall(ss_fall)
    );

    assign rx_byte     = {sr, mosi_s};
    assign rx_done     = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
    assign cur_op      = (state == OPCODE) ? rx_byte : cmd;
    assign a_new       = {addr_sr[ADDR_W-9:0], rx_byte};
    assign rd_idx      = (state == ADDR) ? a_new : ptr;
    assign status_byte = (wel ? STATUS_WEL : 8'h00) | (busy ? STATUS_BUSY : 8'h00);
    assign prog_we     = (state == DATA_IN) && rx_done;
    assign commit      = ss_rise && (state != IDLE);
    assign erase_ok    = commit && (cmd == CMD_ERASE_SECTOR) && (byte_cnt == 3'd4) && wel;
    assign erase_bad   = commit && (cmd == CMD_ERASE_SECTOR) && !((byte_cnt == 3'd4) && wel);

    // Byte to present next on miso, chosen by the active opcode.
    always_comb begin
        tx_nxt = 8'h00;
        if (cur_op == CMD_STATUS)                     tx_nxt = status_byte;
        else if (cur_op == CMD_READ)                  tx_nxt = ~mem_n[rd_idx];
        else if (JEDEC_EN && cur_op == CMD_JEDEC_ID)  tx_nxt = jedec_byte(byte_cnt);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and opcode-time rejection.
    always_comb begin
        state_nxt = state;
        op_err    = 1'b0;
        if (ss_rise) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            if (ss_fall) state_nxt = OPCODE;
        end else if (rx_done) begin
            case (state)
                OPCODE: begin
                    if (busy && rx_byte != CMD_STATUS) begin
                        state_nxt = IGNORE;
                        op_err    = 1'b1;
                    end else begin
                        case (rx_byte)
                            CMD_STATUS:             state_nxt = DATA_OUT;
                            CMD_WR_EN:              state_nxt = IGNORE;
                            CMD_READ,
                            CMD_ERASE_SECTOR:       state_nxt = ADDR;
                            CMD_WRITE: begin
                                state_nxt = wel ? ADDR : IGNORE;
                                op_err    = !wel;
                            end
                            CMD_JEDEC_ID: begin
                                state_nxt = JEDEC_EN ? DATA_OUT : IGNORE;
                                op_err    = !JEDEC_EN;
                            end
                            default: begin
                                state_nxt = IGNORE;
                                op_err    = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (byte_cnt == 3'd3) begin
                        case (cmd)
                            CMD_READ:  state_nxt = DATA_OUT;
                            CMD_WRITE: state_nxt = DATA_IN;
                            default:   state_nxt = IGNORE;
                        endcase
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Shift registers, counters, address pointer and miso driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0; byte_cnt <= '0; sr <= '0; tx <= '0;
            addr_sr <= '0; ptr <= '0; cmd <= '0; prog_wrote <= 1'b0; miso <= 1'b0;
        end else begin
            if (ss_fall || ss_rise) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sclk_rise && state != IDLE) begin
                bit_cnt <= bit_cnt + 3'd1;
                sr      <= rx_byte[6:0];
                if (bit_cnt == 3'd7 && byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
            end
            if (ss_fall) begin
                cmd        <= '0;
                prog_wrote <= 1'b0;
            end
            if (state == OPCODE && rx_done) cmd <= op_err ? 8'h00 : rx_byte;
            if (state == ADDR && rx_done) addr_sr <= a_new;
            if (rx_done && state_nxt == DATA_OUT && cur_op == CMD_READ) ptr <= rd_idx + 1'b1;
            else if (state == ADDR && rx_done && byte_cnt == 3'd3)      ptr <= a_new;
            else if (prog_we)                                           ptr[7:0] <= ptr[7:0] + 8'd1;
            if (prog_we) prog_wrote <= 1'b1;
            if (rx_done && state_nxt == DATA_OUT) tx <= tx_nxt;
            else if (sclk_fall && state == DATA_OUT) tx <= {tx[6:0], 1'b0};
            if (state != DATA_OUT || ss_rise) miso <= 1'b0;
            else if (sclk_fall)               miso <= tx[7];
        end
    end

    // Status bits, busy timer, erase sweep and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0; wel <= 1'b0; busy_cnt <= '0;
            sweep_left <= '0; eptr <= '0; cmd_err <= 1'b0;
        end else begin
            cmd_err <= op_err | erase_bad;
            if (sweep_left != '0) begin
                eptr       <= eptr + 1'b1;
                sweep_left <= sweep_left - 1'b1;
            end
            if (busy) begin
                if (busy_cnt == '0) begin
                    busy <= 1'b0;
                    wel  <= 1'b0;
                end else begin
                    busy_cnt <= busy_cnt - 1'b1;
                end
            end else if (commit) begin
                if (cmd == CMD_WR_EN) begin
                    wel <= 1'b1;
                end else if (cmd == CMD_WRITE && prog_wrote) begin
                    busy     <= 1'b1;
                    busy_cnt <= CNT_W'(PROG_CYCLES - 1);
                end else if (erase_ok) begin
                    busy       <= 1'b1;
                    busy_cnt   <= CNT_W'(ERASE_CYCLES - 1);
                    eptr       <= addr_sr & ~ADDR_W'(SECT - 1);
                    sweep_left <= (ADDR_W + 1)'(SECT);
                end
            end
        end
    end

    // Memory write port (complemented storage): erase clears, program ORs in ~data.
    always_ff @(posedge clk) begin
        if (!rst && sweep_left != '0) mem_n[eptr] <= 8'h00;
        else if (!rst && prog_we)     mem_n[ptr]  <= mem_n[ptr] | ~rx_byte;
    end
endmodule

// File: tb/tb_spi_flash_slave.sv
// Bench for spi_flash_slave: SPI mode-0 master tasks, a flash memory model
// and a scoreboard of expected read bytes compared as the DUT returns them.
module tb_spi_flash_slave;
    import spi_flash_pkg::*;

    localparam int DEPTH = 4096;
    localparam int HALF  = 5;

    logic clk = 1'b0, rst = 1'b1, ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic miso, busy, wel, cmd_err;
    int n_checks = 0, n_pass = 0, err_pulses = 0;
    logic [7:0] model [DEPTH];
    logic [7:0] exp_q[$], got_q[$], wr_q[$];

    spi_flash_slave #(.ADDR_W(12), .PROG_CYCLES(400), .ERASE_CYCLES(5000), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi),
        .miso(miso), .busy(busy), .wel(wel), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_err) err_pulses++;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_hdr(input logic [7:0] op, input logic [23:0] a, input bit with_addr);
        logic [7:0] d;
        ss = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(op, d);
        if (with_addr) begin
            spi_byte(a[23:16], d);
            spi_byte(a[15:8], d);
            spi_byte(a[7:0], d);
        end
    endtask

    task automatic spi_stop;
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic do_status(output logic [7:0] s);
        spi_hdr(CMD_STATUS, 24'h0, 1'b0);
        spi_byte(8'h00, s);
        spi_stop;
    endtask

    task automatic do_wren;
        spi_hdr(CMD_WR_EN, 24'h0, 1'b0);
        spi_stop;
    endtask

    task automatic do_read(input logic [11:0] a, input int n);
        logic [7:0] r;
        logic [11:0] p;
        spi_hdr(CMD_READ, {12'h0, a}, 1'b1);
        for (int i = 0; i < n; i++) begin
            p = a + 12'(i);
            exp_q.push_back(model[p]);
            spi_byte(8'h00, r);
            got_q.push_back(r);
        end
        spi_stop;
    endtask

    task automatic do_program(input logic [11:0] a, input bit accept);
        logic [7:0] d;
        logic [11:0] p;
        spi_hdr(CMD_WRITE, {12'h0, a}, 1'b1);
        for (int i = 0; i < wr_q.size(); i++) begin
            spi_byte(wr_q[i], d);
            p = {a[11:8], a[7:0] + 8'(i)};
            if (accept) model[p] = model[p] & wr_q[i];
        end
        spi_stop;
    endtask

    task automatic poll_idle(output bit ok);
        logic [7:0] s;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            do_status(s);
            if (s == 8'h00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({miso, busy, wel, cmd_err} !== 4'b0000)
            $display("FAIL reset_during: got %b want 0000", {miso, busy, wel, cmd_err});
        else n_pass++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({miso, busy, wel, cmd_err} !== 4'b0000 || dut.state !== IDLE)
            $display("FAIL reset_after: got %b state %0d want 0000 state 0", {miso, busy, wel, cmd_err}, dut.state);
        else n_pass++;
    endtask

    task automatic test_powerup_status;
        logic [7:0] s;
        do_status(s);
        n_checks++;
        if (s !== 8'h00 || busy !== 1'b0 || wel !== 1'b0)
            $display("FAIL powerup_status: got %h busy %b wel %b want 00 0 0", s, busy, wel);
        else n_pass++;
    endtask

    task automatic test_wren;
        logic [7:0] s;
        do_wren;
        do_status(s);
        n_checks++;
        if (s !== 8'h02 || wel !== 1'b1)
            $display("FAIL wren_status: got %h wel %b want 02 1", s, wel);
        else n_pass++;
    endtask

    task automatic test_erase;
        logic [7:0] s, e, g;
        bit ok;
        do_wren;
        spi_hdr(CMD_ERASE_SECTOR, 24'h000000, 1'b1);
        spi_stop;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'hFF;
        do_status(s);
        n_checks++;
        if (s !== 8'h03 || busy !== 1'b1)
            $display("FAIL erase_busy: got %h busy %b want 03 1", s, busy);
        else n_pass++;
        poll_idle(ok);
        n_checks++;
        if (!ok || wel !== 1'b0) $display("FAIL erase_done: idle %0d wel %b want 1 0", ok, wel);
        else n_pass++;
        do_read(12'h000, 16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL erase_read: got %h want %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_program;
        logic [7:0] e, g;
        bit ok;
        do_wren;
        wr_q.delete();
        for (int i = 0; i < 128; i++) wr_q.push_back(8'(i));
        do_program(12'h000, 1'b1);
        poll_idle(ok);
        n_checks++;
        if (!ok || wel !== 1'b0) $display("FAIL program_done: idle %0d wel %b want 1 0", ok, wel);
        else n_pass++;
        do_read(12'h000, 128);
        for (int i = 0; i < 128; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e || g !== 8'(i)) $display("FAIL program_read[%0d]: got %h want %h", i, g, e);
            else n_pass++;
        end
    endtask

    task automatic test_page_wrap;
        logic [7:0] e, g;
        bit ok;
        do_wren;
        wr_q.delete();
        for (int i = 0; i < 300; i++) wr_q.push_back(8'(i * 37 + 11));
        do_program(12'h0F0, 1'b1);
        poll_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL wrap_done: idle %0d want 1", ok);
        else n_pass++;
        do_read(12'h000, 64);
        do_read(12'h0F0, 16);
        do_read(12'h100, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL wrap_read: got %h want %h", g, e);
            else n_pass++;
        end
        do_wren;
        wr_q.delete();
        wr_q.push_back(8'h55);
        do_program(12'h200, 1'b1);
        poll_idle(ok);
        do_wren;
        wr_q.delete();
        wr_q.push_back(8'hFF);
        do_program(12'h200, 1'b1);
        poll_idle(ok);
        do_read(12'h200, 1);
        g = got_q.pop_front();
        e = exp_q.pop_front();
        n_checks++;
        if (g !== 8'h55 || e !== 8'h55) $display("FAIL ff_over_55: got %h want 55", g);
        else n_pass++;
    endtask

    task automatic test_errors;
        logic [7:0] d, e, g;
        int e0;
        bit ok;
        e0 = err_pulses;
        wr_q.delete();
        wr_q.push_back(8'hAA);
        do_program(12'h300, 1'b0);
        n_checks++;
        if (err_pulses !== e0 + 1 || busy !== 1'b0)
            $display("FAIL prog_no_wel: pulses %0d busy %b want %0d 0", err_pulses - e0, busy, 1);
        else n_pass++;
        e0 = err_pulses;
        spi_hdr(8'h3C, 24'h0, 1'b0);
        spi_byte(8'h00, d);
        n_checks++;
        if (miso !== 1'b0) $display("FAIL unknown_miso: got %b want 0", miso);
        else n_pass++;
        spi_stop;
        n_checks++;
        if (err_pulses !== e0 + 1) $display("FAIL unknown_op: pulses %0d want 1", err_pulses - e0);
        else n_pass++;
        do_wren;
        wr_q.delete();
        wr_q.push_back(8'h0F);
        do_program(12'h301, 1'b1);
        e0 = err_pulses;
        do_wren;
        n_checks++;
        if (err_pulses !== e0 + 1 || busy !== 1'b1)
            $display("FAIL wren_busy: pulses %0d busy %b want 1 1", err_pulses - e0, busy);
        else n_pass++;
        poll_idle(ok);
        n_checks++;
        if (!ok || wel !== 1'b0) $display("FAIL wren_busy_after: idle %0d wel %b want 1 0", ok, wel);
        else n_pass++;
        e0 = err_pulses;
        spi_hdr(CMD_ERASE_SECTOR, 24'h000000, 1'b1);
        spi_stop;
        n_checks++;
        if (err_pulses !== e0 + 1 || busy !== 1'b0)
            $display("FAIL erase_no_wel: pulses %0d busy %b want 1 0", err_pulses - e0, busy);
        else n_pass++;
        do_read(12'h300, 2);
        do_read(12'h000, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL err_mem_read: got %h want %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid_read;
        logic [7:0] d, s;
        spi_hdr(CMD_READ, 24'h000000, 1'b1);
        spi_byte(8'h00, d);
        spi_byte(8'h00, d);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (miso !== 1'b0 || dut.state !== IDLE)
            $display("FAIL rst_mid_read: miso %b state %0d want 0 0", miso, dut.state);
        else n_pass++;
        ss = 1'b1;
        repeat (20) @(negedge clk);
        do_status(s);
        n_checks++;
        if (s !== 8'h00) $display("FAIL status_after_rst: got %h want 00", s);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 8'hFF;
        test_reset;
        test_powerup_status;
        test_wren;
        test_erase;
        test_program;
        test_page_wrap;
        test_errors;
        test_rst_mid_read;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
